// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and load-use hazard controller at the ID->EX boundary.
// Tracks the EX and MEM destination records and registers the EX operand mux selects.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic              b_imm_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              reg_we_i,
    input  logic              is_load_i,
    output logic [1:0]        asel_o,
    output logic [1:0]        bsel_o,
    output logic [1:0]        regbsel_o,
    output logic              ex_valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] SEL_REG   = 2'd0;
    localparam logic [1:0] SEL_IMM   = 2'd1;
    localparam logic [1:0] SEL_ALU   = 2'd2;
    localparam logic [1:0] SEL_DATAD = 2'd3;

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_we;
    logic              ex_load;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_we;

    logic       hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2;
    logic [1:0] sel_rs1, sel_rs2, asel_d, bsel_d;

    always_comb begin
        hit_ex_rs1  = ex_valid  & ex_we  & (ex_rd  == rs1_i) & (rs1_i != '0);
        hit_ex_rs2  = ex_valid  & ex_we  & (ex_rd  == rs2_i) & (rs2_i != '0);
        hit_mem_rs1 = mem_valid & mem_we & (mem_rd == rs1_i) & (rs1_i != '0);
        hit_mem_rs2 = mem_valid & mem_we & (mem_rd == rs2_i) & (rs2_i != '0);

        // EX is checked first so the youngest producer wins on a double hit
        sel_rs1 = SEL_REG;
        if (rs1_used_i) begin
            if (hit_ex_rs1)       sel_rs1 = SEL_ALU;
            else if (hit_mem_rs1) sel_rs1 = SEL_DATAD;
        end
        sel_rs2 = SEL_REG;
        if (rs2_used_i) begin
            if (hit_ex_rs2)       sel_rs2 = SEL_ALU;
            else if (hit_mem_rs2) sel_rs2 = SEL_DATAD;
        end

        asel_d = sel_rs1;
        bsel_d = b_imm_i ? SEL_IMM : sel_rs2;

        // rs2 still matters with an immediate B when it feeds the store-data path
        stall_o = id_valid_i & ex_load & ~flush_i &
                  ((rs1_used_i & hit_ex_rs1) |
                   (rs2_used_i & hit_ex_rs2 & (~b_imm_i | rs2_used_i)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_we       <= 1'b0;
            ex_load     <= 1'b0;
            mem_valid   <= 1'b0;
            mem_rd      <= '0;
            mem_we      <= 1'b0;
            asel_o      <= SEL_REG;
            bsel_o      <= SEL_REG;
            regbsel_o   <= SEL_REG;
            stall_cnt_o <= '0;
        end else if (!hold_i) begin
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_we    <= ex_we;
            if (flush_i || stall_o) begin
                ex_valid  <= 1'b0;
                asel_o    <= SEL_REG;
                bsel_o    <= SEL_REG;
                regbsel_o <= SEL_REG;
                if (!flush_i) stall_cnt_o <= stall_cnt_o + 1'b1;
            end else begin
                ex_valid  <= id_valid_i;
                ex_rd     <= rd_i;
                ex_we     <= reg_we_i;
                ex_load   <= is_load_i;
                asel_o    <= asel_d;
                bsel_o    <= bsel_d;
                regbsel_o <= sel_rs2;
            end
        end
    end

    assign ex_valid_o = ex_valid;

endmodule
